// File: rtl/slot_allocator.sv
// ---------------------------------------------------------------------------
// slot_allocator
//
// Tracks occupancy of WIDTH slots. Each cycle the block can grant one free
// slot and release one busy slot. A grant always goes to the highest-index
// free slot, chosen from the occupancy map as it stood before the edge.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   alloc_req   request one free slot this cycle
//   alloc_gnt   registered one-cycle pulse: a slot was granted
//   alloc_id    index of the granted slot; holds its value while alloc_gnt=0
//   free_valid  release the slot named by free_id this cycle
//   free_id     slot index to release
//   busy_map    registered occupancy; bit i set means slot i is allocated
//   busy_cnt    registered count of set bits in busy_map
//   full        busy_cnt == WIDTH
//   empty       busy_cnt == 0
//   free_err    sticky: a release named a slot that was not busy
// ---------------------------------------------------------------------------
module slot_allocator #(
   parameter int WIDTH = 16,             // power of two, 4..64
   parameter int ID_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             alloc_req,
   output logic             alloc_gnt,
   output logic [ID_W-1:0]  alloc_id,
   input  logic             free_valid,
   input  logic [ID_W-1:0]  free_id,
   output logic [WIDTH-1:0] busy_map,
   output logic [ID_W:0]    busy_cnt,
   output logic             full,
   output logic             empty,
   output logic             free_err
);

   localparam logic [ID_W:0] FULL_CNT = (ID_W+1)'(WIDTH);
   localparam logic [ID_W:0] CNT_ONE  = (ID_W+1)'(1);

   logic [WIDTH-1:0] r_busy_map;
   logic [ID_W:0]    r_busy_cnt;
   logic             r_alloc_gnt;
   logic [ID_W-1:0]  r_alloc_id;
   logic             r_free_err;

   logic             w_full;
   logic             w_empty;
   logic [ID_W-1:0]  w_sel;
   logic             w_grant;
   logic             w_free_hit;
   logic             w_free_bad;
   logic [WIDTH-1:0] w_next_map;

   // full/empty come only from the registered count, never from this
   // cycle's requests.
   assign w_full  = (r_busy_cnt == FULL_CNT);
   assign w_empty = (r_busy_cnt == '0);

   // Highest-index zero bit: scanning upward, the last free slot seen wins.
   // When the map is full w_sel is meaningless, but w_grant is then 0.
   // NOTE: every always_comb output gets a default first so no path leaves
   // it unassigned -- otherwise synthesis infers a latch.
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!r_busy_map[i]) w_sel = ID_W'(i);
      end
   end

   assign w_grant    = alloc_req  &  ~w_full;
   assign w_free_hit = free_valid &   r_busy_map[free_id];
   assign w_free_bad = free_valid &  ~r_busy_map[free_id];

   // The freed slot is busy and the selected slot is free, so the two
   // updates never touch the same bit.
   always_comb begin
      w_next_map = r_busy_map;
      if (w_free_hit) w_next_map[free_id] = 1'b0;
      if (w_grant)    w_next_map[w_sel]   = 1'b1;
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy_map  <= '0;
         r_busy_cnt  <= '0;
         r_alloc_gnt <= 1'b0;
         r_alloc_id  <= '0;
         r_free_err  <= 1'b0;
      end else begin
         r_busy_map  <= w_next_map;
         r_alloc_gnt <= w_grant;
         if (w_grant)    r_alloc_id <= w_sel;
         if (w_free_bad) r_free_err <= 1'b1;

         // A grant and a valid free together leave the count unchanged.
         unique case ({w_grant, w_free_hit})
            2'b10:   r_busy_cnt <= r_busy_cnt + CNT_ONE;
            2'b01:   r_busy_cnt <= r_busy_cnt - CNT_ONE;
            default: r_busy_cnt <= r_busy_cnt;
         endcase
      end
   end

   assign busy_map  = r_busy_map;
   assign busy_cnt  = r_busy_cnt;
   assign alloc_gnt = r_alloc_gnt;
   assign alloc_id  = r_alloc_id;
   assign free_err  = r_free_err;
   assign full      = w_full;
   assign empty     = w_empty;

endmodule

// File: tb/tb_slot_allocator.sv
// ---------------------------------------------------------------------------
// tb_slot_allocator
//
// Directed scenarios followed by random traffic. A driver issues one
// request per cycle and pushes the expected post-edge state into a queue;
// a monitor pops one entry one time unit after each rising edge and
// compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_slot_allocator;

   localparam int W    = 16;
   localparam int ID_W = 4;

   typedef struct packed {
      logic            gnt;
      logic [ID_W-1:0] id;
      logic [W-1:0]    map;
      logic [ID_W:0]   cnt;
      logic            err;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alloc_req = 1'b0;
   logic            alloc_gnt;
   logic [ID_W-1:0] alloc_id;
   logic            free_valid = 1'b0;
   logic [ID_W-1:0] free_id = '0;
   logic [W-1:0]    busy_map;
   logic [ID_W:0]   busy_cnt;
   logic            full;
   logic            empty;
   logic            free_err;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t q[$];

   // Reference model state
   logic [W-1:0]    m_map;
   logic            m_err;
   logic [ID_W-1:0] m_last_id;

   slot_allocator #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alloc_req  (alloc_req),
      .alloc_gnt  (alloc_gnt),
      .alloc_id   (alloc_id),
      .free_valid (free_valid),
      .free_id    (free_id),
      .busy_map   (busy_map),
      .busy_cnt   (busy_cnt),
      .full       (full),
      .empty      (empty),
      .free_err   (free_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_map     = '0;
      m_err     = 1'b0;
      m_last_id = '0;
   endtask

   // Drive one cycle of stimulus before the next rising edge, predict the
   // result from the allocation rules, and release the inputs afterwards.
   task automatic step(input logic req, input logic fv, input logic [ID_W-1:0] fid);
      exp_t         e;
      int           sel;
      logic [W-1:0] pre;
      @(negedge clk);
      alloc_req  = req;
      free_valid = fv;
      free_id    = fid;
      pre = m_map;
      sel = -1;
      if (req && $countones(pre) != W) begin
         for (int i = W - 1; i >= 0; i--) begin
            if (sel < 0 && !pre[i]) sel = i;
         end
      end
      if (fv) begin
         if (pre[fid]) m_map[fid] = 1'b0;
         else          m_err = 1'b1;
      end
      if (sel >= 0) begin
         m_map[sel] = 1'b1;
         m_last_id  = ID_W'(sel);
      end
      e.gnt = (sel >= 0);
      e.id  = m_last_id;
      e.map = m_map;
      e.cnt = (ID_W+1)'($countones(m_map));
      e.err = m_err;
      q.push_back(e);
      @(posedge clk);
      #3;
      alloc_req  = 1'b0;
      free_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_gnt"},   64'(alloc_gnt), 64'd0);
      check({tag, "_id"},    64'(alloc_id),  64'd0);
      check({tag, "_map"},   64'(busy_map),  64'd0);
      check({tag, "_cnt"},   64'(busy_cnt),  64'd0);
      check({tag, "_err"},   64'(free_err),  64'd0);
      check({tag, "_empty"}, 64'(empty),     64'd1);
      check({tag, "_full"},  64'(full),      64'd0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset(input string tag);
      @(negedge clk);
      alloc_req  = 1'b0;
      free_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1 check_reset_values(tag);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: one expected entry per issued request, compared right after
   // the edge that produced it.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("gnt",   64'(alloc_gnt), 64'(e.gnt));
            check("id",    64'(alloc_id),  64'(e.id));
            check("map",   64'(busy_map),  64'(e.map));
            check("cnt",   64'(busy_cnt),  64'(e.cnt));
            check("err",   64'(free_err),  64'(e.err));
            check("full",  64'(full),      64'(e.cnt == (ID_W+1)'(W)));
            check("empty", 64'(empty),     64'(e.cnt == '0));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected %0d pending entries to drain", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();

      // Power-on reset
      #3 check_reset_values("por");
      @(negedge clk);
      rst_n = 1'b1;

      // Three allocations: ids 15, 14, 13
      repeat (3) step(1'b1, 1'b0, '0);
      check("three_map", 64'(busy_map), 64'hE000);
      check("three_cnt", 64'(busy_cnt), 64'd3);
      check("three_id",  64'(alloc_id), 64'd13);

      // Seventeen requests from empty: sixteen grants then a dropped one
      pulse_reset("rst_a");
      repeat (17) step(1'b1, 1'b0, '0);
      check("fill_full", 64'(full),      64'd1);
      check("fill_map",  64'(busy_map),  64'hFFFF);
      check("fill_gnt",  64'(alloc_gnt), 64'd0);
      check("fill_id",   64'(alloc_id),  64'd0);

      // Free + alloc while full: free wins, alloc dropped; retry gets 7
      step(1'b1, 1'b1, 4'd7);
      check("ff_gnt", 64'(alloc_gnt), 64'd0);
      check("ff_map", 64'(busy_map),  64'hFF7F);
      check("ff_cnt", 64'(busy_cnt),  64'd15);
      step(1'b1, 1'b0, '0);
      check("retry_id",   64'(alloc_id), 64'd7);
      check("retry_full", 64'(full),     64'd1);

      // Release of an idle slot sets the sticky error
      pulse_reset("rst_b");
      step(1'b1, 1'b0, '0);
      step(1'b0, 1'b1, 4'd3);
      check("bad_map", 64'(busy_map), 64'h8000);
      check("bad_err", 64'(free_err), 64'd1);
      repeat (10) step(1'b0, 1'b0, '0);
      check("sticky_err", 64'(free_err), 64'd1);

      // Simultaneous free of 15 and alloc from C000: grant 13
      pulse_reset("rst_c");
      repeat (2) step(1'b1, 1'b0, '0);
      check("c000_map", 64'(busy_map), 64'hC000);
      step(1'b1, 1'b1, 4'd15);
      check("sim_id",  64'(alloc_id), 64'd13);
      check("sim_map", 64'(busy_map), 64'h6000);
      check("sim_cnt", 64'(busy_cnt), 64'd2);

      // Mid-operation reset discards grants; first allocation after is 15
      pulse_reset("rst_d");
      repeat (5) step(1'b1, 1'b0, '0);
      check("five_map", 64'(busy_map), 64'hF800);
      pulse_reset("rst_mid");
      check_reset_values("post_rel");
      step(1'b1, 1'b0, '0);
      check("post_id",  64'(alloc_id),  64'd15);
      check("post_gnt", 64'(alloc_gnt), 64'd1);

      // Random traffic
      pulse_reset("rst_r");
      for (int n = 0; n < 600; n++) begin
         logic            r_req;
         logic            r_fv;
         logic [ID_W-1:0] r_id;
         r_req = ($urandom_range(0, 99) < 55);
         r_fv  = ($urandom_range(0, 99) < 45);
         r_id  = ID_W'($urandom_range(0, W - 1));
         step(r_req, r_fv, r_id);
         if (n == 300) pulse_reset("rst_rand");
      end

      @(posedge clk);
      #2;
      check("queue_drained", 64'(q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
